acc_multi_reg: RTL

Parametrised accumulator register for the basic-computer datapath, the next generation of the plain 8-bit load/increment/clear accumulator. It holds the AC and the E (extend/carry) flag. It executes the register-reference and ALU operations the control unit issues: load, clear, increment, decrement, add, AND, complement, and rotate through E. It also adds multi-cycle rotate-by-N with a busy/done handshake toward the control sequencer.

---
 rtl/acc_multi_reg.sv | 129 ++++++++++++
 1 files changed

// File: rtl/acc_multi_reg.sv
// rtl/acc_multi_reg.sv - accumulator (AC + E flag) with single-cycle ALU ops and multi-cycle rotate-by-N
module acc_multi_reg #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic [3:0]       OP,
    input  logic             OP_VALID,
    input  logic [WIDTH-1:0] Data,
    input  logic [SHW-1:0]   SHAMT,
    output logic [WIDTH-1:0] Q,
    output logic             E,
    output logic             ZERO,
    output logic             NEG,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [3:0] OP_CLR   = 4'd1;
    localparam logic [3:0] OP_LD    = 4'd2;
    localparam logic [3:0] OP_INC   = 4'd3;
    localparam logic [3:0] OP_DEC   = 4'd4;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_CMA   = 4'd7;
    localparam logic [3:0] OP_CME   = 4'd8;
    localparam logic [3:0] OP_CLE   = 4'd9;
    localparam logic [3:0] OP_CIR   = 4'd10;
    localparam logic [3:0] OP_CIL   = 4'd11;
    localparam logic [3:0] OP_ROR_N = 4'd12;
    localparam logic [3:0] OP_ROL_N = 4'd13;

    typedef enum logic {S_IDLE, S_ROT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             e_q, e_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   sum;

    // Both rotates treat {E,Q} as one WIDTH+1 bit ring; result packed as {E,Q}.
    function automatic logic [WIDTH:0] rot_r(input logic [WIDTH-1:0] q, input logic e);
        return {q[0], e, q[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH:0] rot_l(input logic [WIDTH-1:0] q, input logic e);
        return {q, e};
    endfunction

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            e_q     <= 1'b0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            e_q     <= e_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            done_q  <= done_d;
        end
    end

    assign sum = {1'b0, q_q} + {1'b0, Data};

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        e_d     = e_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (OP_VALID) begin
                    done_d = 1'b1;
                    case (OP)
                        OP_CLR: q_d = '0;
                        OP_LD:  q_d = Data;
                        OP_INC: q_d = q_q + WIDTH'(1);
                        OP_DEC: q_d = q_q - WIDTH'(1);
                        OP_ADD: {e_d, q_d} = sum;
                        OP_AND: q_d = q_q & Data;
                        OP_CMA: q_d = ~q_q;
                        OP_CME: e_d = ~e_q;
                        OP_CLE: e_d = 1'b0;
                        OP_CIR: {e_d, q_d} = rot_r(q_q, e_q);
                        OP_CIL: {e_d, q_d} = rot_l(q_q, e_q);
                        OP_ROR_N, OP_ROL_N: begin
                            if (SHAMT != '0) begin
                                state_d = S_ROT;
                                cnt_d   = SHAMT;
                                left_d  = (OP == OP_ROL_N);
                                done_d  = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_ROT: begin
                {e_d, q_d} = left_q ? rot_l(q_q, e_q) : rot_r(q_q, e_q);
                cnt_d      = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Q    = q_q;
        E    = e_q;
        ZERO = (q_q == '0);
        NEG  = q_q[WIDTH-1];
        BUSY = (state_q == S_ROT);
        DONE = done_q;
    end

endmodule
